// File: rtl/player_life_ctrl.sv
// player_life_ctrl
// Sequences the player through ALIVE, HIT, RESPAWN and DEAD, counts lives,
// blinks the player while invulnerable, gates movement and firing, and emits
// a one-cycle respawn pulse toward the movement block. All timing is in frames.
// Optional build macro: PLAYER_EXTRA_LIFE_EN (bonus_life adds a life).
module player_life_ctrl #(
    parameter int         LIVES          = 3,
    parameter int         HIT_FRAMES     = 64,
    parameter int         RESPAWN_FRAMES = 32,
    parameter int         BLINK_LOG2     = 3,
    parameter logic [3:0] HIT_MASK       = 4'b0001
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [3:0] collision,
    input  logic       restart,
    input  logic       bonus_life,
    input  logic       playerDR_in,
    output logic       playerDR_out,
    output logic       move_enable,
    output logic       fire_enable,
    output logic       respawn,
    output logic [3:0] lives,
    output logic       game_over
);

    localparam int HIT_W   = $clog2(HIT_FRAMES);
    localparam int RESP_W  = $clog2(RESPAWN_FRAMES);
    localparam int BLINK_W = BLINK_LOG2 + 1;
    localparam int BIG_W   = (HIT_W > RESP_W) ? HIT_W : RESP_W;
    localparam int CNT_W   = (BIG_W > BLINK_W) ? BIG_W : BLINK_W;

    // Compare values carry one extra bit so the increment never wraps before the test.
    localparam logic [CNT_W:0] HIT_END    = (CNT_W + 1)'(HIT_FRAMES);
    localparam logic [CNT_W:0] RESP_END   = (CNT_W + 1)'(RESPAWN_FRAMES);
    localparam logic [CNT_W:0] CNT_ONE    = (CNT_W + 1)'(1);
    localparam logic [3:0]     LIVES_INIT = 4'(LIVES);

    typedef enum logic [1:0] {
        ALIVE,
        HIT,
        RESPAWN,
        DEAD
    } lifeState_e;

    lifeState_e       state;
    logic [CNT_W-1:0] frameCnt;
    logic [CNT_W:0]   frameNext;
    logic             hit;
    logic             bonus;
    logic             visible;
    logic [3:0]       livesInc;

    assign hit       = |(collision & HIT_MASK);
    assign frameNext = {1'b0, frameCnt} + CNT_ONE;
    assign livesInc  = (lives == 4'd15) ? lives : lives + 4'd1;

`ifdef PLAYER_EXTRA_LIFE_EN
    assign bonus = bonus_life;
`else
    // Port kept for a uniform interface; it has no effect in this build.
    logic unusedBonusLife;
    assign unusedBonusLife = bonus_life;
    assign bonus           = 1'b0;
`endif

    // Blink decode from the registered state and frame counter.
    always_comb begin
        // NOTE: default assigned first so every path drives visible and no latch is inferred.
        visible = 1'b1;
        case (state)
            HIT, RESPAWN: visible = ~frameCnt[BLINK_LOG2];
            DEAD:         visible = 1'b0;
            default:      visible = 1'b1;
        endcase
    end

    // Drawing request is gated with zero added latency.
    assign playerDR_out = playerDR_in & visible;

    // Life-state sequencer with registered control outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ALIVE;
            lives       <= LIVES_INIT;
            frameCnt    <= '0;
            respawn     <= 1'b0;
            game_over   <= 1'b0;
            move_enable <= 1'b1;
            fire_enable <= 1'b1;
        end else begin
            // NOTE: non-blocking everywhere here, so every branch sees pre-edge values.
            respawn <= 1'b0;
            case (state)
                ALIVE: begin
                    if (hit) begin
                        frameCnt    <= '0;
                        move_enable <= 1'b0;
                        fire_enable <= 1'b0;
                        if (bonus) begin
                            state <= HIT;
                        end else if (lives > 4'd1) begin
                            lives <= lives - 4'd1;
                            state <= HIT;
                        end else begin
                            lives     <= 4'd0;
                            state     <= DEAD;
                            game_over <= 1'b1;
                        end
                    end else if (bonus) begin
                        lives <= livesInc;
                    end
                end
                HIT: begin
                    if (bonus) begin
                        lives <= livesInc;
                    end
                    if (startOfFrame) begin
                        if (frameNext == HIT_END) begin
                            frameCnt    <= '0;
                            state       <= RESPAWN;
                            respawn     <= 1'b1;
                            move_enable <= 1'b1;
                        end else begin
                            frameCnt <= frameNext[CNT_W-1:0];
                        end
                    end
                end
                RESPAWN: begin
                    if (bonus) begin
                        lives <= livesInc;
                    end
                    if (startOfFrame) begin
                        if (frameNext == RESP_END) begin
                            frameCnt    <= '0;
                            state       <= ALIVE;
                            fire_enable <= 1'b1;
                        end else begin
                            frameCnt <= frameNext[CNT_W-1:0];
                        end
                    end
                end
                DEAD: begin
                    if (restart) begin
                        lives       <= LIVES_INIT;
                        frameCnt    <= '0;
                        state       <= RESPAWN;
                        respawn     <= 1'b1;
                        game_over   <= 1'b0;
                        move_enable <= 1'b1;
                        fire_enable <= 1'b0;
                    end
                end
                default: state <= ALIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_life_ctrl.sv
// tb_player_life_ctrl
// Directed bench for player_life_ctrl with a frame-based reference model that
// is compared against the DUT every falling clock edge, plus literal spot checks.
module tb_player_life_ctrl;

    localparam int         LIVES          = 2;
    localparam int         HIT_FRAMES     = 4;
    localparam int         RESPAWN_FRAMES = 2;
    localparam int         BLINK_LOG2     = 1;
    localparam logic [3:0] HIT_MASK       = 4'b0001;

    localparam int P_ALIVE   = 0;
    localparam int P_HIT     = 1;
    localparam int P_RESPAWN = 2;
    localparam int P_DEAD    = 3;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic [3:0] collision;
    logic       restart;
    logic       bonus_life;
    logic       playerDR_in;
    logic       playerDR_out;
    logic       move_enable;
    logic       fire_enable;
    logic       respawn;
    logic [3:0] lives;
    logic       game_over;

    int passCount  = 0;
    int checkCount = 0;

    player_life_ctrl #(
        .LIVES         (LIVES),
        .HIT_FRAMES    (HIT_FRAMES),
        .RESPAWN_FRAMES(RESPAWN_FRAMES),
        .BLINK_LOG2    (BLINK_LOG2),
        .HIT_MASK      (HIT_MASK)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .collision   (collision),
        .restart     (restart),
        .bonus_life  (bonus_life),
        .playerDR_in (playerDR_in),
        .playerDR_out(playerDR_out),
        .move_enable (move_enable),
        .fire_enable (fire_enable),
        .respawn     (respawn),
        .lives       (lives),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: a phase, a life count and frames remaining in the phase.
    int mPhase     = P_ALIVE;
    int mLives     = LIVES;
    int mLeft      = 0;
    int mTotal     = 0;
    int mRespawn   = 0;
    bit mHitIn;
    bit mBonusIn;

    function automatic int modelVisible();
        int elapsed;
        if (mPhase == P_DEAD) return 0;
        if (mPhase == P_ALIVE) return 1;
        elapsed = mTotal - mLeft;
        return (((elapsed >> BLINK_LOG2) & 1) == 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mPhase   = P_ALIVE;
            mLives   = LIVES;
            mLeft    = 0;
            mTotal   = 0;
            mRespawn = 0;
        end else begin
            mHitIn   = (collision & HIT_MASK) != 4'd0;
            mBonusIn = 1'b0;
`ifdef PLAYER_EXTRA_LIFE_EN
            mBonusIn = bonus_life;
`endif
            mRespawn = 0;
            if (mPhase == P_ALIVE && mHitIn) begin
                if (mBonusIn || mLives > 1) begin
                    if (!mBonusIn) mLives = mLives - 1;
                    mPhase = P_HIT;
                    mLeft  = HIT_FRAMES;
                    mTotal = HIT_FRAMES;
                end else begin
                    mLives = 0;
                    mPhase = P_DEAD;
                end
            end else if (mPhase == P_DEAD) begin
                if (restart) begin
                    mLives   = LIVES;
                    mPhase   = P_RESPAWN;
                    mLeft    = RESPAWN_FRAMES;
                    mTotal   = RESPAWN_FRAMES;
                    mRespawn = 1;
                end
            end else begin
                if (mBonusIn && mLives < 15) mLives = mLives + 1;
                if (mPhase != P_ALIVE && startOfFrame) begin
                    mLeft = mLeft - 1;
                    if (mLeft == 0) begin
                        if (mPhase == P_HIT) begin
                            mPhase   = P_RESPAWN;
                            mLeft    = RESPAWN_FRAMES;
                            mTotal   = RESPAWN_FRAMES;
                            mRespawn = 1;
                        end else begin
                            mPhase = P_ALIVE;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("lives", int'(lives), mLives);
        check("game_over", int'(game_over), (mPhase == P_DEAD) ? 1 : 0);
        check("move_enable", int'(move_enable), (mPhase == P_ALIVE || mPhase == P_RESPAWN) ? 1 : 0);
        check("fire_enable", int'(fire_enable), (mPhase == P_ALIVE) ? 1 : 0);
        check("respawn", int'(respawn), mRespawn);
        check("playerDR_out", int'(playerDR_out), int'(playerDR_in) & modelVisible());
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    int blinkExp[4] = '{1, 1, 0, 0};

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        collision    = 4'd0;
        restart      = 1'b0;
        bonus_life   = 1'b0;
        playerDR_in  = 1'b1;
        step();
        step();
        resetN = 1'b1;
        step();

        // Reset state and zero-latency drawing gate.
        check("rst lives", int'(lives), 2);
        check("rst game_over", int'(game_over), 0);
        check("rst move", int'(move_enable), 1);
        check("rst fire", int'(fire_enable), 1);
        check("rst respawn", int'(respawn), 0);
        check("rst dr hi", int'(playerDR_out), 1);
        playerDR_in = 1'b0;
        #1;
        check("rst dr lo", int'(playerDR_out), 0);
        playerDR_in = 1'b1;

        // Masked collision bit and a stray restart do nothing in ALIVE.
        collision = 4'b0010;
        repeat (3) step();
        collision = 4'd0;
        check("masked lives", int'(lives), 2);
        check("masked move", int'(move_enable), 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart ignored", int'(respawn), 0);

        // Held collision costs exactly one life.
        collision = 4'b0001;
        step();
        check("hit lives", int'(lives), 1);
        check("hit move", int'(move_enable), 0);
        check("hit fire", int'(fire_enable), 0);
        repeat (9) step();
        collision = 4'd0;
        check("held lives", int'(lives), 1);

        // Blink over HIT frames 0..3, then the respawn pulse.
        for (int f = 0; f < 4; f++) begin
            check($sformatf("blink f%0d", f), int'(playerDR_out), blinkExp[f]);
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            if (f < 3) step();
        end
        check("respawn pulse", int'(respawn), 1);
        check("respawn move", int'(move_enable), 1);
        check("respawn fire", int'(fire_enable), 0);
        step();
        check("respawn drop", int'(respawn), 0);

        // Collision ignored in RESPAWN, then back to ALIVE after two frames.
        collision    = 4'b0001;
        startOfFrame = 1'b1;
        step();
        collision    = 4'd0;
        startOfFrame = 1'b0;
        check("resp ignore hit", int'(lives), 1);
        step();
        frame();
        check("alive move", int'(move_enable), 1);
        check("alive fire", int'(fire_enable), 1);

`ifndef PLAYER_EXTRA_LIFE_EN
        bonus_life = 1'b1;
        step();
        bonus_life = 1'b0;
        check("bonus ignored", int'(lives), 1);
`endif

        // Last life lost: DEAD ignores collisions and frames until restart.
        collision = 4'b0001;
        step();
        collision = 4'd0;
        check("dead lives", int'(lives), 0);
        check("dead game_over", int'(game_over), 1);
        check("dead dr", int'(playerDR_out), 0);
        collision    = 4'b0001;
        startOfFrame = 1'b1;
        repeat (3) step();
        collision    = 4'd0;
        startOfFrame = 1'b0;
        check("dead hold lives", int'(lives), 0);
        check("dead hold go", int'(game_over), 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart lives", int'(lives), 2);
        check("restart go", int'(game_over), 0);
        check("restart pulse", int'(respawn), 1);
        check("restart fire", int'(fire_enable), 0);
        step();
        check("restart drop", int'(respawn), 0);
        frame();
        frame();
        check("restart alive", int'(fire_enable), 1);

        // Asynchronous reset in the middle of HIT.
        collision = 4'b0001;
        step();
        collision = 4'd0;
        frame();
        frame();
        check("mid hit blink", int'(playerDR_out), 0);
        resetN = 1'b0;
        #1;
        check("async lives", int'(lives), 2);
        check("async move", int'(move_enable), 1);
        check("async fire", int'(fire_enable), 1);
        check("async dr", int'(playerDR_out), 1);
        step();
        resetN = 1'b1;
        step();
        check("post rst lives", int'(lives), 2);
        check("post rst fire", int'(fire_enable), 1);

`ifdef PLAYER_EXTRA_LIFE_EN
        // Hit with bonus on the last life enters HIT without dying; saturation at 15.
        collision = 4'b0001;
        step();
        collision = 4'd0;
        repeat (HIT_FRAMES + RESPAWN_FRAMES) frame();
        check("xl pre lives", int'(lives), 1);
        collision  = 4'b0001;
        bonus_life = 1'b1;
        step();
        collision  = 4'd0;
        bonus_life = 1'b0;
        check("xl hit lives", int'(lives), 1);
        check("xl no dead", int'(game_over), 0);
        check("xl in hit", int'(move_enable), 0);
        bonus_life = 1'b1;
        repeat (20) step();
        bonus_life = 1'b0;
        check("xl saturate", int'(lives), 15);
`endif

        step();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
